// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: arbitrates exception entry, ERET, redirects, stalls
// and sequential advance, buffering a redirect that lands during a stall.
//
// state | meaning
// RUN   | normal fetch; PC advances, redirects or holds on stall
// HOLD  | a redirect is buffered in pend_tgt until the stall releases
// FLUSH | one advancing cycle after exception/ERET; stale redirects ignored
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] PC_MIN    = 32'h0000_3000,
    parameter logic [31:0] PC_MAX    = 32'h0000_6ffc
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Br_Valid,
    input  logic [31:0] Br_Target,
    input  logic        Exc_Req,
    input  logic        Eret_Req,
    input  logic [31:0] EPC,
    output logic [31:0] PC,
    output logic [31:0] PC8_Out,
    output logic        Redirect_Pending,
    output logic        Addr_Exc
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;

        // Exception and ERET override any stall or buffered redirect.
        if (Exc_Req) begin
            pc_d       = EXC_ENTRY;
            state_d    = FLUSH;
            pend_tgt_d = '0;
        end else if (Eret_Req) begin
            pc_d       = EPC;
            state_d    = FLUSH;
            pend_tgt_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (Br_Valid && !Stall) begin
                        pc_d = Br_Target;
                    end else if (Br_Valid && Stall) begin
                        pend_tgt_d = Br_Target;
                        state_d    = HOLD;
                    end else if (!Stall) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                HOLD: begin
                    // Br_Valid here is a repeat from the same stalled instruction.
                    if (!Stall) begin
                        pc_d    = pend_tgt_q;
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    if (!Stall) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign PC               = pc_q;
    assign PC8_Out          = pc_q + 32'd8;
    assign Redirect_Pending = (state_q == HOLD);
    assign Addr_Exc         = (pc_q[1:0] != 2'b00) || (pc_q < PC_MIN) || (pc_q > PC_MAX);

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: per-feature tasks push expected PC state
// into a scoreboard as stimulus is applied and pop it after each clock edge.
module tb_fetch_pc_ctrl;

    logic        Clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall = 1'b0;
    logic        Br_Valid = 1'b0;
    logic [31:0] Br_Target = '0;
    logic        Exc_Req = 1'b0;
    logic        Eret_Req = 1'b0;
    logic [31:0] EPC = '0;
    logic [31:0] PC;
    logic [31:0] PC8_Out;
    logic        Redirect_Pending;
    logic        Addr_Exc;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        stall;
        logic        bv;
        logic [31:0] bt;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] pc;
        logic        pend;
        logic        aexc;
    } step_t;

    step_t sb[$];

    fetch_pc_ctrl dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Br_Valid(Br_Valid), .Br_Target(Br_Target),
        .Exc_Req(Exc_Req), .Eret_Req(Eret_Req), .EPC(EPC), .PC(PC), .PC8_Out(PC8_Out),
        .Redirect_Pending(Redirect_Pending), .Addr_Exc(Addr_Exc)
    );

    always #5 if (clk_en) Clk = ~Clk;

    function automatic step_t mk(logic st, logic bv, logic [31:0] bt, logic exc, logic eret,
                                 logic [31:0] epc, logic [31:0] pc, logic pend, logic aexc);
        step_t s;
        s = '{stall: st, bv: bv, bt: bt, exc: exc, eret: eret, epc: epc,
              pc: pc, pend: pend, aexc: aexc};
        return s;
    endfunction

    task automatic drive_step(input step_t s);
        Stall     = s.stall;
        Br_Valid  = s.bv;
        Br_Target = s.bt;
        Exc_Req   = s.exc;
        Eret_Req  = s.eret;
        EPC       = s.epc;
        sb.push_back(s);
    endtask

    task automatic test_reset();
        step_t e;
        #3;
        Rst = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3000, 0, 0));
        #1;
        e = sb.pop_front();
        checks++;
        if ({PC, PC8_Out, Redirect_Pending, Addr_Exc} !== {e.pc, e.pc + 32'd8, e.pend, e.aexc}) begin
            errors++;
            $display("FAIL reset_async got pc=%h pc8=%h pend=%b aexc=%b want pc=%h pc8=%h pend=%b aexc=%b",
                     PC, PC8_Out, Redirect_Pending, Addr_Exc, e.pc, e.pc + 32'd8, e.pend, e.aexc);
        end
        clk_en = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_sequential_redirect();
        step_t q[$];
        step_t e;
        q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3004, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3008, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h300c, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3010, 0, 0));
        q.push_back(mk(0, 1, 32'h3100, 0, 0, 0, 32'h3100, 0, 0));
        q.push_back(mk(0, 1, 32'h3020, 0, 0, 0, 32'h3020, 0, 0));
        for (int i = 0; i < q.size(); i++) begin
            drive_step(q[i]);
            @(posedge Clk); #1;
            e = sb.pop_front();
            checks++;
            if ({PC, PC8_Out, Redirect_Pending, Addr_Exc} !== {e.pc, e.pc + 32'd8, e.pend, e.aexc}) begin
                errors++;
                $display("FAIL seq_redirect[%0d] got pc=%h pc8=%h pend=%b aexc=%b want pc=%h pc8=%h pend=%b aexc=%b",
                         i, PC, PC8_Out, Redirect_Pending, Addr_Exc, e.pc, e.pc + 32'd8, e.pend, e.aexc);
            end
        end
    endtask

    task automatic test_buffered_redirect();
        step_t q[$];
        step_t e;
        q.push_back(mk(1, 1, 32'h3200, 0, 0, 0, 32'h3020, 1, 0));
        q.push_back(mk(1, 1, 32'h3300, 0, 0, 0, 32'h3020, 1, 0));
        q.push_back(mk(1, 1, 32'h3300, 0, 0, 0, 32'h3020, 1, 0));
        q.push_back(mk(0, 1, 32'h3300, 0, 0, 0, 32'h3200, 0, 0));
        for (int i = 0; i < q.size(); i++) begin
            drive_step(q[i]);
            @(posedge Clk); #1;
            e = sb.pop_front();
            checks++;
            if ({PC, PC8_Out, Redirect_Pending, Addr_Exc} !== {e.pc, e.pc + 32'd8, e.pend, e.aexc}) begin
                errors++;
                $display("FAIL buffered[%0d] got pc=%h pc8=%h pend=%b aexc=%b want pc=%h pc8=%h pend=%b aexc=%b",
                         i, PC, PC8_Out, Redirect_Pending, Addr_Exc, e.pc, e.pc + 32'd8, e.pend, e.aexc);
            end
        end
    endtask

    task automatic test_exc_precedence();
        step_t q[$];
        step_t e;
        q.push_back(mk(1, 1, 32'h3400, 0, 0, 0, 32'h3200, 1, 0));
        q.push_back(mk(1, 0, 0, 1, 1, 32'h3040, 32'h4180, 0, 0));
        q.push_back(mk(0, 1, 32'h3500, 0, 0, 0, 32'h4184, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h4188, 0, 0));
        for (int i = 0; i < q.size(); i++) begin
            drive_step(q[i]);
            @(posedge Clk); #1;
            e = sb.pop_front();
            checks++;
            if ({PC, PC8_Out, Redirect_Pending, Addr_Exc} !== {e.pc, e.pc + 32'd8, e.pend, e.aexc}) begin
                errors++;
                $display("FAIL exc_prec[%0d] got pc=%h pc8=%h pend=%b aexc=%b want pc=%h pc8=%h pend=%b aexc=%b",
                         i, PC, PC8_Out, Redirect_Pending, Addr_Exc, e.pc, e.pc + 32'd8, e.pend, e.aexc);
            end
        end
    endtask

    task automatic test_eret_flush();
        step_t q[$];
        step_t e;
        q.push_back(mk(0, 0, 0, 0, 1, 32'h3044, 32'h3044, 0, 0));
        q.push_back(mk(1, 1, 32'h3600, 0, 0, 0, 32'h3044, 0, 0));
        q.push_back(mk(0, 1, 32'h3600, 0, 0, 0, 32'h3048, 0, 0));
        q.push_back(mk(0, 1, 32'h3600, 0, 0, 0, 32'h3600, 0, 0));
        for (int i = 0; i < q.size(); i++) begin
            drive_step(q[i]);
            @(posedge Clk); #1;
            e = sb.pop_front();
            checks++;
            if ({PC, PC8_Out, Redirect_Pending, Addr_Exc} !== {e.pc, e.pc + 32'd8, e.pend, e.aexc}) begin
                errors++;
                $display("FAIL eret_flush[%0d] got pc=%h pc8=%h pend=%b aexc=%b want pc=%h pc8=%h pend=%b aexc=%b",
                         i, PC, PC8_Out, Redirect_Pending, Addr_Exc, e.pc, e.pc + 32'd8, e.pend, e.aexc);
            end
        end
    endtask

    task automatic test_addr_check();
        step_t q[$];
        step_t e;
        q.push_back(mk(0, 1, 32'h3002, 0, 0, 0, 32'h3002, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3006, 0, 1));
        q.push_back(mk(0, 1, 32'h7000, 0, 0, 0, 32'h7000, 0, 1));
        q.push_back(mk(0, 1, 32'h6ffc, 0, 0, 0, 32'h6ffc, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h7000, 0, 1));
        q.push_back(mk(0, 1, 32'h2ffc, 0, 0, 0, 32'h2ffc, 0, 1));
        q.push_back(mk(0, 1, 32'h3000, 0, 0, 0, 32'h3000, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 1, 32'hffff_fffc, 32'hffff_fffc, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 1));
        for (int i = 0; i < q.size(); i++) begin
            drive_step(q[i]);
            @(posedge Clk); #1;
            e = sb.pop_front();
            checks++;
            if ({PC, PC8_Out, Redirect_Pending, Addr_Exc} !== {e.pc, e.pc + 32'd8, e.pend, e.aexc}) begin
                errors++;
                $display("FAIL addr_check[%0d] got pc=%h pc8=%h pend=%b aexc=%b want pc=%h pc8=%h pend=%b aexc=%b",
                         i, PC, PC8_Out, Redirect_Pending, Addr_Exc, e.pc, e.pc + 32'd8, e.pend, e.aexc);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        step_t e;
        drive_step(mk(1, 1, 32'h3100, 0, 0, 0, 32'h0000_0000, 1, 1));
        @(posedge Clk); #1;
        e = sb.pop_front();
        checks++;
        if ({PC, PC8_Out, Redirect_Pending, Addr_Exc} !== {e.pc, e.pc + 32'd8, e.pend, e.aexc}) begin
            errors++;
            $display("FAIL enter_hold got pc=%h pc8=%h pend=%b aexc=%b want pc=%h pc8=%h pend=%b aexc=%b",
                     PC, PC8_Out, Redirect_Pending, Addr_Exc, e.pc, e.pc + 32'd8, e.pend, e.aexc);
        end
        #2;
        Rst = 1'b1;
        sb.push_back(mk(1, 1, 32'h3100, 0, 0, 0, 32'h3000, 0, 0));
        #1;
        e = sb.pop_front();
        checks++;
        if ({PC, PC8_Out, Redirect_Pending, Addr_Exc} !== {e.pc, e.pc + 32'd8, e.pend, e.aexc}) begin
            errors++;
            $display("FAIL reset_mid_hold got pc=%h pc8=%h pend=%b aexc=%b want pc=%h pc8=%h pend=%b aexc=%b",
                     PC, PC8_Out, Redirect_Pending, Addr_Exc, e.pc, e.pc + 32'd8, e.pend, e.aexc);
        end
        @(negedge Clk);
        Rst = 1'b0;
        drive_step(mk(0, 0, 0, 0, 0, 0, 32'h3004, 0, 0));
        @(posedge Clk); #1;
        e = sb.pop_front();
        checks++;
        if ({PC, PC8_Out, Redirect_Pending, Addr_Exc} !== {e.pc, e.pc + 32'd8, e.pend, e.aexc}) begin
            errors++;
            $display("FAIL after_reset got pc=%h pc8=%h pend=%b aexc=%b want pc=%h pc8=%h pend=%b aexc=%b",
                     PC, PC8_Out, Redirect_Pending, Addr_Exc, e.pc, e.pc + 32'd8, e.pend, e.aexc);
        end
    endtask

    initial begin
        test_reset();
        test_sequential_redirect();
        test_buffered_redirect();
        test_exc_precedence();
        test_eret_flush();
        test_addr_check();
        test_reset_mid_hold();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d leftover want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
